cc_lane_writer: RTL and testbench
=================================

// Module: cc_lane_writer
// PURPOSE
//  Writer side of the 8-row game matrix consumed by the matrix comparator and display.
//  Holds eight DATAWIDTH-bit lane registers, loads an initial level pattern over a valid/ready port,
//  then rotates the traffic lanes on a prescaled tick.
//  Freezes the matrix when the comparator reports a crash (active-low), until a new start.
// PARAMETERS
//  LANEWRITER_DATAWIDTH   8          width of each lane register (bits per row)
//  LANEWRITER_BASEPERIOD  25000000   clock cycles per shift at speed 0; must be a multiple of 8
// PORTS
//  CC_LANEWRITER_CLOCK_50          in   1   system clock, all state on rising edge
//  CC_LANEWRITER_RESET_InHigh      in   1   asynchronous, active-high reset
//  CC_LANEWRITER_start_InHigh      in   1   one-cycle pulse: begin (re)loading level pattern
//  CC_LANEWRITER_loadValid_InHigh  in   1   loadData valid this cycle
//  CC_LANEWRITER_loadData_InBUS    in   DW  row pattern, rows delivered in order 0..7
//  CC_LANEWRITER_loadReady_OutHigh out  1   writer accepts loadData this cycle
//  CC_LANEWRITER_speed_InBUS       in   2   shift rate select: period = BASEPERIOD >> speed
//  CC_LANEWRITER_crash_InLow       in   1   crash from comparator, 0 = crash
//  CC_LANEWRITER_tick_OutHigh      out  1   one-cycle pulse in the cycle the lanes shift
//  CC_LANEWRITER_state_OutBUS      out  2   00 IDLE, 01 LOAD, 10 RUN, 11 FREEZE
//  CC_LANEWRITER_registro0..7_OutBUS out DW lane registers 0..7, registered outputs
// BEHAVIOUR
//  Reset (async, any state): all registro = 0, loadReady = 0, tick = 0, state = IDLE,
//   row pointer = 0, prescaler = 0. Release is synchronous to the next rising edge.
//  FSM (registered):
//   IDLE: outputs hold; start -> LOAD.
//   LOAD: loadReady = 1 (combinational from state). Beat = valid & ready. Each beat writes
//    loadData to registro[ptr], ptr++. Beat with ptr = 7 -> RUN next cycle, ptr -> 0.
//    No beat -> hold. Gaps in valid are legal.
//   RUN: prescaler counts 0..period-1; on count >= period-1, tick = 1, count -> 0, lanes shift.
//    crash_InLow = 0 -> FREEZE next cycle; crash has priority over a coincident tick (no shift).
//   FREEZE: registers, prescaler hold; tick = 0; only start leaves (-> LOAD).
//   start in any non-reset state -> LOAD next cycle, ptr = 0, prescaler = 0; rows keep old
//    value until overwritten. start overrides crash and any coincident tick.
//  crash_InLow is ignored in IDLE and LOAD.
//  Shift rule (same edge as tick): rows 0 and 7 (sidewalks) never change.
//   Odd rows 1,3,5 rotate left by 1 (MSB wraps to bit 0).
//   Even rows 2,4,6 rotate right by 1 (bit 0 wraps to MSB). Rotation is lossless.
//  Speed: period = BASEPERIOD >> speed (speed 0 slowest).
//   speed may change at any time; compare is >=, so a shorter period ticks on the next cycle
//   if count already exceeds it. Prescaler width = clog2(BASEPERIOD).
//  tick is registered: high exactly the cycle registro shows the shifted value.
//  Latency: loadData visible on registro the cycle after its beat.
//   crash -> FREEZE state visible 1 cycle later.
// TESTING  (BASEPERIOD = 8)
//  1 Reset mid-RUN with nonzero rows -> all registro = 0x00, state = 00, loadReady = 0 immediately (async).
//  2 start, then load 00,81,0F,F0,01,80,3C,00 with valid low on beats 3 and 6
//    -> rows match, loadReady high only in LOAD, state = 10 after 8th beat.
//  3 speed = 0 in RUN -> tick after 8 cycles; row1 81->03, row2 0F->87,
//    row3 F0->E1, row4 01->80; rows 0,7 unchanged.
//  4 crash_InLow = 0 on the tick cycle -> no shift, tick = 0, state = 11; rows hold 20 cycles; start -> 01.
//  5 speed = 3 (period 1) -> tick every cycle; row6 3C->1E->0F->87.
//  6 start pulse mid-RUN with loadValid held high -> LOAD, ptr = 0, next 8 beats overwrite rows 0..7, then RUN.

Source files
------------

// File: rtl/cc_lane_writer.sv
// cc_lane_writer: writer side of the 8-row game matrix.
// Loads a level pattern row by row over a valid/ready port. It then rotates the
// traffic lanes on a prescaled tick. The matrix freezes on a crash until the next start.
module cc_lane_writer #(
  parameter int LANEWRITER_DATAWIDTH  = 8,
  parameter int LANEWRITER_BASEPERIOD = 25000000
) (
  input  logic                            CC_LANEWRITER_CLOCK_50,
  input  logic                            CC_LANEWRITER_RESET_InHigh,
  input  logic                            CC_LANEWRITER_start_InHigh,
  input  logic                            CC_LANEWRITER_loadValid_InHigh,
  input  logic [LANEWRITER_DATAWIDTH-1:0] CC_LANEWRITER_loadData_InBUS,
  output logic                            CC_LANEWRITER_loadReady_OutHigh,
  input  logic [1:0]                      CC_LANEWRITER_speed_InBUS,
  input  logic                            CC_LANEWRITER_crash_InLow,
  output logic                            CC_LANEWRITER_tick_OutHigh,
  output logic [1:0]                      CC_LANEWRITER_state_OutBUS,
  output logic [LANEWRITER_DATAWIDTH-1:0] CC_LANEWRITER_registro0_OutBUS,
  output logic [LANEWRITER_DATAWIDTH-1:0] CC_LANEWRITER_registro1_OutBUS,
  output logic [LANEWRITER_DATAWIDTH-1:0] CC_LANEWRITER_registro2_OutBUS,
  output logic [LANEWRITER_DATAWIDTH-1:0] CC_LANEWRITER_registro3_OutBUS,
  output logic [LANEWRITER_DATAWIDTH-1:0] CC_LANEWRITER_registro4_OutBUS,
  output logic [LANEWRITER_DATAWIDTH-1:0] CC_LANEWRITER_registro5_OutBUS,
  output logic [LANEWRITER_DATAWIDTH-1:0] CC_LANEWRITER_registro6_OutBUS,
  output logic [LANEWRITER_DATAWIDTH-1:0] CC_LANEWRITER_registro7_OutBUS
);

  localparam int DW = LANEWRITER_DATAWIDTH;
  localparam int PW = $clog2(LANEWRITER_BASEPERIOD);
  // BASEPERIOD is a multiple of 8, so (BASE-1) >> speed equals (BASE >> speed) - 1 exactly.
  localparam logic [PW-1:0] BASE_M1 = PW'(LANEWRITER_BASEPERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_RUN    = 2'b10,
    ST_FREEZE = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [DW-1:0] rows_q [8];
  logic [DW-1:0] rows_d [8];
  logic [PW-1:0] limit_s;
  logic          beat_s;

  // Rotate left by one: MSB wraps to bit 0.
  function automatic logic [DW-1:0] rot_left(input logic [DW-1:0] v);
    return {v[DW-2:0], v[DW-1]};
  endfunction

  // Rotate right by one: bit 0 wraps to MSB.
  function automatic logic [DW-1:0] rot_right(input logic [DW-1:0] v);
    return {v[0], v[DW-1:1]};
  endfunction

  assign limit_s = BASE_M1 >> CC_LANEWRITER_speed_InBUS;
  assign CC_LANEWRITER_loadReady_OutHigh = (state_q == ST_LOAD);
  assign beat_s = CC_LANEWRITER_loadValid_InHigh & CC_LANEWRITER_loadReady_OutHigh;

  // Next-state logic: start dominates, then per-state load / run / freeze behaviour.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rows_d[i] = rows_q[i];
    end
    if (CC_LANEWRITER_start_InHigh) begin
      state_d = ST_LOAD;
      ptr_d   = 3'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_LOAD: begin
          if (beat_s) begin
            rows_d[ptr_q] = CC_LANEWRITER_loadData_InBUS;
            ptr_d = ptr_q + 3'd1;
            if (ptr_q == 3'd7) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            ptr_d = ptr_q;
          end
        end
        ST_RUN: begin
          // Crash wins over a coincident tick: the frame that caused it stays on screen.
          if (!CC_LANEWRITER_crash_InLow) begin
            state_d = ST_FREEZE;
          end else if (cnt_q >= limit_s) begin
            tick_d = 1'b1;
            cnt_d  = '0;
            rows_d[1] = rot_left(rows_q[1]);
            rows_d[3] = rot_left(rows_q[3]);
            rows_d[5] = rot_left(rows_q[5]);
            rows_d[2] = rot_right(rows_q[2]);
            rows_d[4] = rot_right(rows_q[4]);
            rows_d[6] = rot_right(rows_q[6]);
          end else begin
            cnt_d = cnt_q + PW'(1);
          end
        end
        ST_FREEZE: begin
          state_d = ST_FREEZE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, pointer, prescaler, tick and lane registers.
  always_ff @(posedge CC_LANEWRITER_CLOCK_50 or posedge CC_LANEWRITER_RESET_InHigh) begin
    if (CC_LANEWRITER_RESET_InHigh) begin
      state_q <= ST_IDLE;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        rows_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      for (int i = 0; i < 8; i++) begin
        rows_q[i] <= rows_d[i];
      end
    end
  end

  assign CC_LANEWRITER_tick_OutHigh     = tick_q;
  assign CC_LANEWRITER_state_OutBUS     = state_q;
  assign CC_LANEWRITER_registro0_OutBUS = rows_q[0];
  assign CC_LANEWRITER_registro1_OutBUS = rows_q[1];
  assign CC_LANEWRITER_registro2_OutBUS = rows_q[2];
  assign CC_LANEWRITER_registro3_OutBUS = rows_q[3];
  assign CC_LANEWRITER_registro4_OutBUS = rows_q[4];
  assign CC_LANEWRITER_registro5_OutBUS = rows_q[5];
  assign CC_LANEWRITER_registro6_OutBUS = rows_q[6];
  assign CC_LANEWRITER_registro7_OutBUS = rows_q[7];

endmodule

// File: tb/tb_cc_lane_writer.sv
// Directed bench for cc_lane_writer with BASEPERIOD = 8.
module tb_cc_lane_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic [1:0] speed;
  logic       crash_n;
  logic       tick;
  logic [1:0] state;
  logic [7:0] rows_s [8];

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] pat     [8];
  logic [7:0] exp_row [8];

  cc_lane_writer #(
    .LANEWRITER_DATAWIDTH(8),
    .LANEWRITER_BASEPERIOD(8)
  ) dut (
    .CC_LANEWRITER_CLOCK_50(clk),
    .CC_LANEWRITER_RESET_InHigh(rst),
    .CC_LANEWRITER_start_InHigh(start),
    .CC_LANEWRITER_loadValid_InHigh(valid),
    .CC_LANEWRITER_loadData_InBUS(data),
    .CC_LANEWRITER_loadReady_OutHigh(ready),
    .CC_LANEWRITER_speed_InBUS(speed),
    .CC_LANEWRITER_crash_InLow(crash_n),
    .CC_LANEWRITER_tick_OutHigh(tick),
    .CC_LANEWRITER_state_OutBUS(state),
    .CC_LANEWRITER_registro0_OutBUS(rows_s[0]),
    .CC_LANEWRITER_registro1_OutBUS(rows_s[1]),
    .CC_LANEWRITER_registro2_OutBUS(rows_s[2]),
    .CC_LANEWRITER_registro3_OutBUS(rows_s[3]),
    .CC_LANEWRITER_registro4_OutBUS(rows_s[4]),
    .CC_LANEWRITER_registro5_OutBUS(rows_s[5]),
    .CC_LANEWRITER_registro6_OutBUS(rows_s[6]),
    .CC_LANEWRITER_registro7_OutBUS(rows_s[7])
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                         input logic [7:0] r3, input logic [7:0] r4, input logic [7:0] r5,
                         input logic [7:0] r6, input logic [7:0] r7);
    exp_row[0] = r0; exp_row[1] = r1; exp_row[2] = r2; exp_row[3] = r3;
    exp_row[4] = r4; exp_row[5] = r5; exp_row[6] = r6; exp_row[7] = r7;
  endtask

  task automatic check_rows(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_row%0d", tag, i), {24'd0, rows_s[i]}, {24'd0, exp_row[i]});
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_to_load", {30'd0, state}, 32'd1);
  endtask

  // Feeds pat[0..7]; with_gaps drops valid before the 3rd and 6th beats.
  task automatic load_pattern(input bit with_gaps);
    int  beat = 0;
    int  cyc  = 0;
    bit  g3   = 1'b0;
    bit  g6   = 1'b0;
    while (beat < 8 && cyc < 40) begin
      check("ready_in_load", {31'd0, ready}, 32'd1);
      if (with_gaps && ((beat == 2 && !g3) || (beat == 5 && !g6))) begin
        valid = 1'b0;
        data  = 8'hEE;
        if (beat == 2) g3 = 1'b1; else g6 = 1'b1;
        step();
      end else begin
        valid = 1'b1;
        data  = pat[beat];
        beat++;
        step();
        check($sformatf("load_row%0d", beat - 1), {24'd0, rows_s[beat - 1]}, {24'd0, pat[beat - 1]});
      end
      cyc++;
    end
    check("load_beats", beat, 32'd8);
    valid = 1'b0;
    check("load_to_run", {30'd0, state}, 32'd2);
    check("ready_off_run", {31'd0, ready}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; data = 8'h00; speed = 2'd0; crash_n = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    // Reset state.
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_tick",  {31'd0, tick},  32'd0);
    set_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check_rows("rst");
    step();
    check("idle_hold", {30'd0, state}, 32'd0);

    // Load with gaps.
    pat[0] = 8'h00; pat[1] = 8'h81; pat[2] = 8'h0F; pat[3] = 8'hF0;
    pat[4] = 8'h01; pat[5] = 8'h80; pat[6] = 8'h3C; pat[7] = 8'h00;
    do_start();
    load_pattern(1'b1);
    set_exp(8'h00, 8'h81, 8'h0F, 8'hF0, 8'h01, 8'h80, 8'h3C, 8'h00);
    check_rows("loaded");

    // Speed 0: first tick after 8 RUN cycles.
    speed = 2'd0;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("pre_tick%0d", i), {31'd0, tick}, 32'd0);
    end
    step();
    check("tick_at_8", {31'd0, tick}, 32'd1);
    set_exp(8'h00, 8'h03, 8'h87, 8'hE1, 8'h80, 8'h01, 8'h1E, 8'h00);
    check_rows("shift1");

    // Crash coincident with the next tick: no shift, freeze.
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("gap_tick%0d", i), {31'd0, tick}, 32'd0);
    end
    crash_n = 1'b0;
    step();
    check("crash_state", {30'd0, state}, 32'd3);
    check("crash_tick",  {31'd0, tick},  32'd0);
    check_rows("crash");
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("freeze_state%0d", i), {30'd0, state}, 32'd3);
      check($sformatf("freeze_tick%0d", i), {31'd0, tick}, 32'd0);
    end
    check_rows("frozen");
    crash_n = 1'b1;
    do_start();

    // Reload, then a shorter period on an over-limit count and speed 3.
    load_pattern(1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("s0_tick%0d", i), {31'd0, tick}, 32'd0);
    end
    speed = 2'd2;
    step();
    check("speed_change_tick", {31'd0, tick}, 32'd1);
    check("sc_row6", {24'd0, rows_s[6]}, 32'h1E);
    check("sc_row1", {24'd0, rows_s[1]}, 32'h03);
    speed = 2'd3;
    step();
    check("s3_tick_a", {31'd0, tick}, 32'd1);
    check("s3_row6_a", {24'd0, rows_s[6]}, 32'h0F);
    step();
    check("s3_tick_b", {31'd0, tick}, 32'd1);
    check("s3_row6_b", {24'd0, rows_s[6]}, 32'h87);
    check("s3_row0", {24'd0, rows_s[0]}, 32'h00);
    check("s3_row7", {24'd0, rows_s[7]}, 32'h00);

    // Start mid-RUN with valid held high; start overrides the coincident tick.
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h44; pat[3] = 8'h88;
    pat[4] = 8'hA5; pat[5] = 8'h5A; pat[6] = 8'hFF; pat[7] = 8'h7E;
    valid = 1'b1;
    data  = 8'h55;
    do_start();
    check("restart_tick", {31'd0, tick}, 32'd0);
    check("restart_row6", {24'd0, rows_s[6]}, 32'h87);
    load_pattern(1'b0);
    set_exp(8'h11, 8'h22, 8'h44, 8'h88, 8'hA5, 8'h5A, 8'hFF, 8'h7E);
    check_rows("reload");

    // Async reset mid-RUN with nonzero rows.
    step();
    check("pre_rst_row2", {24'd0, rows_s[2]}, 32'h22);
    rst = 1'b1;
    #1;
    check("arst_state", {30'd0, state}, 32'd0);
    check("arst_ready", {31'd0, ready}, 32'd0);
    check("arst_tick",  {31'd0, tick},  32'd0);
    set_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    check_rows("arst");
    step();
    rst = 1'b0;
    step();
    check("post_rst_state", {30'd0, state}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
